// File: rtl/wbcon_pkg.sv
// -----------------------------------------------------------------------------
// wbcon_pkg
// Shared definitions for the wbcon link (rx -> exec -> tx) and host software:
// response op codes, header magic nibble, header bit positions and helper
// functions that encode a command result into the response header byte.
// No ports (package).
// -----------------------------------------------------------------------------
package wbcon_pkg;

   localparam logic [1:0] WBCON_OP_NULL        = 2'b00;
   localparam logic [1:0] WBCON_OP_SET_ADDRESS = 2'b01;
   localparam logic [1:0] WBCON_OP_WRITE_WORD  = 2'b10;
   localparam logic [1:0] WBCON_OP_READ_WORD   = 2'b11;

   localparam logic [3:0] WBCON_HDR_MAGIC = 4'hA;

   localparam int WBCON_HDR_OP_LSB  = 0;
   localparam int WBCON_HDR_OP_MSB  = 1;
   localparam int WBCON_HDR_ERR_BIT = 2;
   localparam int WBCON_HDR_RTY_BIT = 3;

   // Priority encode the op flags: read > write > set_address > null.
   // An explicit null flag and "no flag at all" encode identically.
   function automatic logic [1:0] wbcon_opcode(input logic op_null,
                                               input logic op_set_address,
                                               input logic op_write_word,
                                               input logic op_read_word);
      logic [1:0] op;
      if (op_read_word)        op = WBCON_OP_READ_WORD;
      else if (op_write_word)  op = WBCON_OP_WRITE_WORD;
      else if (op_set_address) op = WBCON_OP_SET_ADDRESS;
      else if (op_null)        op = WBCON_OP_NULL;
      else                     op = WBCON_OP_NULL;
      return op;
   endfunction

   // Header byte = {magic, rty, err, op}.
   function automatic logic [7:0] wbcon_hdr(input logic [1:0] op,
                                            input logic       err,
                                            input logic       rty);
      logic [7:0] h;
      h                                     = '0;
      h[7:4]                                = WBCON_HDR_MAGIC;
      h[WBCON_HDR_RTY_BIT]                  = rty;
      h[WBCON_HDR_ERR_BIT]                  = err;
      h[WBCON_HDR_OP_MSB:WBCON_HDR_OP_LSB]  = op;
      return h;
   endfunction

endpackage

// File: rtl/wbcon_tx.sv
// -----------------------------------------------------------------------------
// wbcon_tx
// Response serializer: accepts one command result (CRES) per handshake and
// emits a header byte, followed by the read data LSB first when the command
// was a successful read, onto an AXI-S style byte stream.
// Ports:
//   i_clk, i_rst_n          clock (posedge), async active-low reset
//   i_cres_tvalid/o_cres_tready   CRES handshake
//   i_cres_op_*             op flags (null/set_address/write_word/read_word)
//   i_cres_hw_data          read data (WB_DATA_WIDTH bits)
//   i_cres_bus_err/_rty     WB cycle terminated by ERR / RTY
//   o_tx_tvalid/i_tx_tready/o_tx_tdata   byte stream toward the TX path
// -----------------------------------------------------------------------------
module wbcon_tx
   import wbcon_pkg::*;
#(
   parameter int WB_DATA_WIDTH = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_cres_tvalid,
   output logic                     o_cres_tready,
   input  logic                     i_cres_op_null,
   input  logic                     i_cres_op_set_address,
   input  logic                     i_cres_op_write_word,
   input  logic                     i_cres_op_read_word,
   input  logic [WB_DATA_WIDTH-1:0] i_cres_hw_data,
   input  logic                     i_cres_bus_err,
   input  logic                     i_cres_bus_rty,
   output logic                     o_tx_tvalid,
   input  logic                     i_tx_tready,
   output logic [7:0]               o_tx_tdata
);

   localparam int DATA_BYTES = WB_DATA_WIDTH / 8;
   localparam int BCNT_WIDTH = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [BCNT_WIDTH-1:0] LAST_CNT = BCNT_WIDTH'(DATA_BYTES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0]               state_q, state_d;
   logic                     ready_q, ready_d;
   logic [1:0]               op_q, op_d;
   logic                     err_q, err_d;
   logic                     rty_q, rty_d;
   logic [WB_DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BCNT_WIDTH-1:0]    cnt_q, cnt_d;

   logic cres_ack;
   logic tx_ack;
   logic read_ok;

   // ready_q is only ever high while in IDLE, so it alone qualifies the accept.
   assign cres_ack = i_cres_tvalid & ready_q;
   assign tx_ack   = o_tx_tvalid & i_tx_tready;
   assign read_ok  = (op_q == WBCON_OP_READ_WORD) && !err_q && !rty_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      err_d   = err_q;
      rty_d   = rty_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cres_ack) begin
               op_d    = wbcon_opcode(i_cres_op_null, i_cres_op_set_address,
                                      i_cres_op_write_word, i_cres_op_read_word);
               err_d   = i_cres_bus_err;
               rty_d   = i_cres_bus_rty;
               shift_d = i_cres_hw_data;
               cnt_d   = '0;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            if (tx_ack) state_d = read_ok ? ST_DATA : ST_IDLE;
         end
         ST_DATA: begin
            if (tx_ack) begin
               shift_d = shift_q >> 8;
               if (cnt_q == LAST_CNT) state_d = ST_IDLE;
               else                   cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered ready: follows the state we are about to be in, so it rises
      // the cycle after reset release and on the same edge that returns to IDLE.
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         op_q    <= WBCON_OP_NULL;
         err_q   <= 1'b0;
         rty_q   <= 1'b0;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         op_q    <= op_d;
         err_q   <= err_d;
         rty_q   <= rty_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode straight from the state, so an async reset drops
   // o_tx_tvalid immediately and nothing stale survives into the next response.
   assign o_cres_tready = ready_q;
   assign o_tx_tvalid   = (state_q != ST_IDLE);

   always_comb begin
      o_tx_tdata = 8'h00;
      case (state_q)
         ST_HDR:  o_tx_tdata = wbcon_hdr(op_q, err_q, rty_q);
         ST_DATA: o_tx_tdata = shift_q[7:0];
         default: o_tx_tdata = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_wbcon_tx.sv
module tb_wbcon_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cres_tvalid;
   logic        cres_tready;
   logic        op_null, op_set, op_write, op_read;
   logic [31:0] hw_data;
   logic        bus_err, bus_rty;
   logic        tx_tvalid;
   logic        tx_tready;
   logic [7:0]  tx_tdata;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   wbcon_tx #(.WB_DATA_WIDTH(32)) dut (
      .i_clk                 (clk),
      .i_rst_n               (rst_n),
      .i_cres_tvalid         (cres_tvalid),
      .o_cres_tready         (cres_tready),
      .i_cres_op_null        (op_null),
      .i_cres_op_set_address (op_set),
      .i_cres_op_write_word  (op_write),
      .i_cres_op_read_word   (op_read),
      .i_cres_hw_data        (hw_data),
      .i_cres_bus_err        (bus_err),
      .i_cres_bus_rty        (bus_rty),
      .o_tx_tvalid           (tx_tvalid),
      .i_tx_tready           (tx_tready),
      .o_tx_tdata            (tx_tdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: the byte sequence a response must produce, from the rules.
   task automatic model(input logic s, input logic w, input logic r,
                        input logic e, input logic t, input logic [31:0] d);
      int op;
      op = r ? 3 : (w ? 2 : (s ? 1 : 0));
      exp_q.delete();
      exp_q.push_back({4'hA, t, e, 2'(op)});
      if (op == 3 && !e && !t)
         for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (cres_tready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_rdy"}, {31'd0, cres_tready}, 32'd1);
   endtask

   task automatic drive_cres(input logic nl, input logic s, input logic w, input logic r,
                             input logic e, input logic t, input logic [31:0] d);
      op_null = nl; op_set = s; op_write = w; op_read = r;
      bus_err = e; bus_rty = t; hw_data = d;
      cres_tvalid = 1'b1;
   endtask

   // Scramble CRES fields while the response is in flight; they must be ignored.
   task automatic scramble();
      {op_null, op_set, op_write, op_read} = 4'($urandom);
      bus_err = 1'($urandom);
      bus_rty = 1'($urandom);
      hw_data = $urandom;
   endtask

   task automatic send(input logic nl, input logic s, input logic w, input logic r,
                       input logic e, input logic t, input logic [31:0] d,
                       input bit rnd_ready, input string tag);
      int  idx, cyc;
      bit  tr;
      model(s, w, r, e, t, d);
      wait_ready(tag);
      drive_cres(nl, s, w, r, e, t, d);
      tx_tready = 1'b0;
      @(negedge clk);
      scramble();
      idx = 0;
      cyc = 0;
      while (idx < exp_q.size() && cyc < 200) begin
         check({tag, "_vld"}, {31'd0, tx_tvalid}, 32'd1);
         check({tag, "_byte"}, {24'd0, tx_tdata}, {24'd0, exp_q[idx]});
         check({tag, "_crdy_lo"}, {31'd0, cres_tready}, 32'd0);
         tr = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         tx_tready = tr;
         @(negedge clk);
         cyc++;
         if (tr) idx++;
      end
      check({tag, "_count"}, idx, exp_q.size());
      check({tag, "_vld_end"}, {31'd0, tx_tvalid}, 32'd0);
      check({tag, "_crdy_end"}, {31'd0, cres_tready}, 32'd1);
      cres_tvalid = 1'b0;
      tx_tready   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      cres_tvalid = 1'b0;
      op_null = 1'b0; op_set = 1'b0; op_write = 1'b0; op_read = 1'b0;
      hw_data = '0; bus_err = 1'b0; bus_rty = 1'b0;
      tx_tready = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_vld",  {31'd0, tx_tvalid}, 32'd0);
      check("rst_data", {24'd0, tx_tdata}, 32'd0);
      check("rst_crdy", {31'd0, cres_tready}, 32'd0);
      rst_n = 1'b1;
      #1 check("rel_crdy_lo", {31'd0, cres_tready}, 32'd0);
      @(negedge clk);
      check("rel_crdy_hi", {31'd0, cres_tready}, 32'd1);

      // directed responses
      send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11223344, 1'b0, "t1_read");
      send(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, "t2_wr_err");
      send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, "t3_rd_rty");
      send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 1'b1, "t4_stall");
      send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, "t5_null");
      send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h9ABCDEF0, 1'b0, "t5_setaddr");
      send(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A55A5A, 1'b0, "t5_prio");
      send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, "t5_noflag");
      send(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h01020304, 1'b1, "t5_rd_both");

      // randomized responses
      for (int k = 0; k < 25; k++) begin
         send(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              $urandom, 1'b1, "rnd");
      end

      // reset during the second data byte
      model(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55667788);
      wait_ready("t6");
      drive_cres(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55667788);
      @(negedge clk);
      cres_tvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("t6_byte", {24'd0, tx_tdata}, {24'd0, exp_q[k]});
         tx_tready = 1'b1;
         @(negedge clk);
      end
      check("t6_byte2", {24'd0, tx_tdata}, {24'd0, exp_q[2]});
      tx_tready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_vld",  {31'd0, tx_tvalid}, 32'd0);
      check("t6_rst_crdy", {31'd0, cres_tready}, 32'd0);
      check("t6_rst_data", {24'd0, tx_tdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11223344, 1'b1, "t6_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
